demux4x32_stage: RTL and testbench
==================================

Name: demux4x32_stage

Overview:
- Registered 1-to-4 demultiplexer for a 32-bit valid/ready stream; the distribution-side counterpart of the 4-to-1 operand/write-back selectors in the CPU.
- Takes one word plus a 2-bit destination select and delivers it to exactly one of four sink channels through a single output register stage.
- Used to route results (e.g. load data, CSR/peripheral writes) from one producer to four consumers without a combinational path from sink ready to source.
- Words aimed at disabled channels are consumed, dropped and counted.

Parameters:
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  source word valid.
- ready_o  output  1  stage can accept a source word this cycle.
- data_i  input  32  source word.
- sel_i  input  2  destination channel: 00=ch0, 01=ch1, 10=ch2, 11=ch3.
- chan_en_i  input  4  per-channel enable, sampled at acceptance.
- valid_o  output  4  per-channel valid, one-hot or zero.
- ready_i  input  4  per-channel sink ready.
- data_o  output  32  held word, shared by all channels.
- drop_cnt_o  output  DROP_CNT_W  number of dropped words, saturating.
- clr_drop_i  input  1  synchronous clear of drop_cnt_o.

Behaviour:
- State:
  - full_q: slot occupied.
  - dest_q[1:0]: destination of the held word.
  - data_q[31:0]: held word.
  - drop_q: drop counter.
- Reset (rst_ni=0, asynchronous): full_q=0, dest_q=0, data_q=0, drop_q=0.
  - Therefore valid_o=0000, data_o=0, drop_cnt_o=0, ready_o=1 while in reset and on the first edge after release.
  - Reset mid-transfer discards the held word; no sink sees it.
- Outputs:
  - valid_o[k] = full_q & (dest_q==k); never more than one bit set.
  - data_o = data_q, stable while full_q=1 and not drained.
- Drain: out_fire = full_q & ready_i[dest_q]. ready_i of non-selected channels is ignored.
- Accept: ready_o = ~full_q | out_fire, so a word may be accepted in the same cycle the held word drains. Throughput is 1 word/cycle when the sink is always ready. ready_o does not depend on valid_i, sel_i or chan_en_i.
- Acceptance: in_fire = valid_i & ready_o.
  - If chan_en_i[sel_i]=1: data_q<=data_i, dest_q<=sel_i, full_q<=1.
  - If chan_en_i[sel_i]=0: the word is dropped.
    - The slot is not loaded.
    - full_q <= full_q & ~out_fire.
    - drop_q increments by 1 unless it is all-ones (saturates).
- No accept: if out_fire and not (in_fire & enabled), full_q<=0; data_q and dest_q are held.
- Latency: a word accepted on edge N is visible on valid_o/data_o after edge N; earliest sink handshake is at edge N+1.
- Holding: when valid_o[k]=1 and ready_i[k]=0, data_o and valid_o stay unchanged until the drain (AXI-style, no retraction).
- Channel enable: chan_en_i only gates acceptance. Deasserting it while a word is held for that channel does not cancel the word.
- Drop counter:
  - clr_drop_i=1 sets drop_q<=0 and takes priority over a same-cycle increment.
  - A same-cycle drop is lost and not counted.
- valid_i may drop without a handshake. The block places no requirement on source stability; only in_fire matters.
- data_i and sel_i are don't-care when valid_i=0.

Test Plan:
- Reset/idle: hold rst_ni=0 with valid_i=1 -> valid_o=0000, ready_o=1, data_o=0, drop_cnt_o=0. Assert rst_ni low asynchronously while full -> valid_o=0000 immediately.
- Single route: chan_en_i=1111, send 0xDEADBEEF with sel=10, ready_i=0100 -> after one edge valid_o=0100, data_o=0xDEADBEEF; handshake completes at the next edge; then valid_o=0000.
- Back-pressure: ready_i=0000 with a word held -> ready_o=0; a new word 0x1 (sel=00) is not accepted; data_o stays held. Raise ready_i[sel] -> drain and accept in the same edge; next cycle valid_o=0001, data_o=0x1.
- Streaming: 8 back-to-back words 0..7 with sel=i%4, ready_i=1111 -> one word out per cycle, in order, on channel i%4, no bubbles.
- Drop: chan_en_i=1110, send 3 words with sel=00 -> valid_o stays 0000, drop_cnt_o=3. clr_drop_i together with a 4th drop -> drop_cnt_o=0.
- Saturation and isolation: with DROP_CNT_W=2, send 5 drops -> drop_cnt_o=3. With a word held for ch1, ready_i=1101 (ch1 not ready) -> no drain.

Source files
------------

// File: rtl/demux4x32_stage.sv
`default_nettype none
// ============================================================================
// Module      : demux4x32_stage
// Description : Registered 1-to-4 demultiplexer for a 32-bit valid/ready
//               stream. One source word plus a 2-bit destination select is
//               captured into a single output register and presented to
//               exactly one of four sink channels. Words aimed at a disabled
//               channel are consumed, dropped and counted in a saturating
//               drop counter.
//
// Ports       :
//   clk_i       in   1           clock, all state on rising edge
//   rst_ni      in   1           asynchronous active-low reset
//   valid_i     in   1           source word valid
//   ready_o     out  1           stage can accept a source word this cycle
//   data_i      in   32          source word
//   sel_i       in   2           destination channel (0..3)
//   chan_en_i   in   4           per-channel enable, sampled at acceptance
//   valid_o     out  4           per-channel valid, one-hot or zero
//   ready_i     in   4           per-channel sink ready
//   data_o      out  32          held word, shared by all channels
//   drop_cnt_o  out  DROP_CNT_W  saturating count of dropped words
//   clr_drop_i  in   1           synchronous clear of drop_cnt_o
//
// Revision    : 1.0 - initial release
// ============================================================================
module demux4x32_stage #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           data_i,
    input  logic [1:0]            sel_i,
    input  logic [3:0]            chan_en_i,
    output logic [3:0]            valid_o,
    input  logic [3:0]            ready_i,
    output logic [31:0]           data_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    input  logic                  clr_drop_i
);

    localparam logic [DROP_CNT_W-1:0] c_drop_max = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] c_drop_one = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                  r_full;
    logic [1:0]            r_dest;
    logic [31:0]           r_data;
    logic [DROP_CNT_W-1:0] r_drop;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic w_out_fire;
    logic w_in_fire;
    logic w_sel_en;
    logic w_load;
    logic w_drop;
    logic w_drop_sat;

    // Only the ready of the channel the held word is aimed at matters.
    assign w_out_fire = r_full & ready_i[r_dest];

    // Ready depends on slot state and sink ready only, so there is no path
    // from valid_i/sel_i/chan_en_i back to the source.
    assign ready_o    = ~r_full | w_out_fire;

    assign w_in_fire  = valid_i & ready_o;
    assign w_sel_en   = chan_en_i[sel_i];
    assign w_load     = w_in_fire & w_sel_en;
    assign w_drop     = w_in_fire & ~w_sel_en;
    assign w_drop_sat = (r_drop == c_drop_max);

    // ------------------------------------------------------------------------
    // Slot register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_full <= 1'b0;
            r_dest <= 2'd0;
            r_data <= 32'd0;
        end else begin
            if (w_load) begin
                // A new word may replace one draining on this same edge.
                r_full <= 1'b1;
                r_dest <= sel_i;
                r_data <= data_i;
            end else if (w_out_fire) begin
                // Drained with no replacement (including the drop case);
                // data and destination are held so data_o stays stable.
                r_full <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drop counter: clear wins over a same-cycle drop, which is then lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop <= '0;
        end else if (clr_drop_i) begin
            r_drop <= '0;
        end else if (w_drop && !w_drop_sat) begin
            r_drop <= r_drop + c_drop_one;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < 4; k++) begin : g_valid
            assign valid_o[k] = r_full & (r_dest == k[1:0]);
        end
    endgenerate

    assign data_o     = r_data;
    assign drop_cnt_o = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_demux4x32_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux4x32_stage
// Description : Self-checking bench for demux4x32_stage. A reference model
//               tracks the in-flight word in a queue and the drop total as an
//               unbounded integer; a monitor compares DUT outputs against it
//               on every falling edge. A second instance with a 2-bit drop
//               counter shares the stimulus to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4x32_stage;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } word_t;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] data_i;
    logic [1:0]  sel_i;
    logic [3:0]  chan_en_i;
    logic [3:0]  ready_i;
    logic        clr_drop_i;

    logic        ready_o,  ready_o2;
    logic [3:0]  valid_o,  valid_o2;
    logic [31:0] data_o,   data_o2;
    logic [15:0] drop_cnt;
    logic [1:0]  drop_cnt2;

    int vectors;
    int miscompares;

    // Reference model state
    word_t       q[$];
    logic [31:0] last_data;
    int          drops;

    demux4x32_stage #(.DROP_CNT_W(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .sel_i(sel_i), .chan_en_i(chan_en_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .drop_cnt_o(drop_cnt), .clr_drop_i(clr_drop_i)
    );

    demux4x32_stage #(.DROP_CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o2),
        .data_i(data_i), .sel_i(sel_i), .chan_en_i(chan_en_i),
        .valid_o(valid_o2), .ready_i(ready_i), .data_o(data_o2),
        .drop_cnt_o(drop_cnt2), .clr_drop_i(clr_drop_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one slot, words leave in acceptance order.
    // ------------------------------------------------------------------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last_data = 32'd0;
            drops     = 0;
        end else begin
            bit fire, rdy;
            fire = (q.size() > 0) && ready_i[q[0].sel];
            rdy  = (q.size() == 0) || fire;
            if (fire) void'(q.pop_front());
            if (valid_i && rdy) begin
                if (chan_en_i[sel_i]) begin
                    q.push_back('{sel: sel_i, data: data_i});
                    last_data = data_i;
                end else if (!clr_drop_i) begin
                    drops++;
                end
            end
            if (clr_drop_i) drops = 0;
        end
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [3:0] exp_valid;
        logic       exp_ready;
        if (q.size() > 0) begin
            exp_valid = 4'b0001 << q[0].sel;
            exp_ready = ready_i[q[0].sel];
        end else begin
            exp_valid = 4'b0000;
            exp_ready = 1'b1;
        end
        chk("valid_o",   {28'd0, valid_o}, {28'd0, exp_valid});
        chk("data_o",    data_o, last_data);
        chk("ready_o",   {31'd0, ready_o}, {31'd0, exp_ready});
        chk("drop_cnt",  {16'd0, drop_cnt}, (drops > 65535) ? 32'd65535 : drops);
        chk("drop_cnt2", {30'd0, drop_cnt2}, (drops > 3) ? 32'd3 : drops);
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic [1:0] s,
                       input logic [3:0] en, input logic [3:0] rdy, input logic clr);
        valid_i = v; data_i = d; sel_i = s; chan_en_i = en; ready_i = rdy; clr_drop_i = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        valid_i = 1'b1; data_i = 32'hA5A5A5A5; sel_i = 2'd1;
        chan_en_i = 4'hF; ready_i = 4'hF; clr_drop_i = 1'b0;

        // Reset held with valid asserted: nothing may be captured.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {28'd0, valid_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_data",  data_o, 32'd0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 4'hF, 4'h0, 0);

        // Single route to ch2.
        cyc(1, 32'hDEADBEEF, 2'b10, 4'hF, 4'b0000, 0);
        chk("route_valid", {28'd0, valid_o}, 32'h4);
        chk("route_data",  data_o, 32'hDEADBEEF);
        cyc(0, 0, 0, 4'hF, 4'b0100, 0);
        chk("route_drained", {28'd0, valid_o}, 32'h0);

        // Back-pressure: hold a word, a new one must wait.
        cyc(1, 32'h12345678, 2'b01, 4'hF, 4'b0000, 0);
        repeat (3) cyc(1, 32'h1, 2'b00, 4'hF, 4'b0000, 0);
        chk("bp_hold", data_o, 32'h12345678);
        cyc(1, 32'h1, 2'b00, 4'hF, 4'b0010, 0);
        chk("bp_next_valid", {28'd0, valid_o}, 32'h1);
        chk("bp_next_data",  data_o, 32'h1);
        cyc(0, 0, 0, 4'hF, 4'hF, 0);

        // Streaming, back-to-back.
        for (int i = 0; i < 8; i++) cyc(1, i, i[1:0], 4'hF, 4'hF, 0);
        cyc(0, 0, 0, 4'hF, 4'hF, 0);

        // Drops on disabled ch0, then clear with a simultaneous drop.
        for (int i = 0; i < 3; i++) cyc(1, 32'hBAD0 + i, 2'b00, 4'b1110, 4'hF, 0);
        cyc(0, 0, 0, 4'hF, 4'hF, 0);
        chk("drop3", {16'd0, drop_cnt}, 32'd3);
        cyc(1, 32'hBAD3, 2'b00, 4'b1110, 4'hF, 1);
        chk("drop_clr", {16'd0, drop_cnt}, 32'd0);

        // Saturation of the narrow counter.
        for (int i = 0; i < 5; i++) cyc(1, i, 2'b11, 4'b0111, 4'hF, 0);
        chk("sat2", {30'd0, drop_cnt2}, 32'd3);
        chk("sat16", {16'd0, drop_cnt}, 32'd5);

        // Isolation: other channels' ready must not drain ch1.
        cyc(1, 32'hC0FFEE01, 2'b01, 4'hF, 4'b1101, 0);
        repeat (3) cyc(0, 0, 0, 4'h0, 4'b1101, 0);
        chk("iso_valid", {28'd0, valid_o}, 32'h2);
        cyc(0, 0, 0, 4'h0, 4'b0010, 0);

        // Asynchronous reset while full.
        cyc(1, 32'h55AA55AA, 2'b11, 4'hF, 4'b0000, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {28'd0, valid_o}, 32'd0);
        chk("async_rst_data",  data_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] en;
            en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            cyc(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom),
                en, 4'($urandom), 1'($urandom_range(0, 40) == 0));
        end
        repeat (4) cyc(0, 0, 0, 4'hF, 4'hF, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
